ascon_bd_sequencer: RTL and testbench
=====================================

ASCON_BD_SEQUENCER -- requirements
Module: ascon_bd_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024, max cycles allowed between issuing a beat and its toggle echo.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 s_valid  input  1  command/block request valid.
REQ-005 s_ready  output  1  sequencer accepts a request.
REQ-006 s_data  input  128  block payload, MSB-first.
REQ-007 s_type  input  4  transaction type (CONF, KEY, NONCE, TAG, AD, SKIP_AD, PLAIN, CIPHER, OK codes from the shared constants header).
REQ-008 s_flags  input  5  config bits [5:1], passed through unchanged on every beat.
REQ-009 s_nbeats  input  4  beats to transfer, 1..8; 0 is treated as 1, values >8 as 8.
REQ-010 m_valid  output  1  response valid.
REQ-011 m_ready  input  1  response consumer ready.
REQ-012 m_data  output  128  collected engine output words, last beat in [15:0].
REQ-013 m_auth  output  1  bd_out_config[3] sampled at the final echo.
REQ-014 m_timeout  output  1  response was terminated by timeout.
REQ-015 bd_in_data  output  16  engine data word.
REQ-016 bd_in_config  output  16  {5'b0, type[3:0], last, flags[4:0], toggle}.
REQ-017 bd_out_data  input  16  engine response word.
REQ-018 bd_out_config  input  16  engine status; bit 2 = toggle echo, bit 3 = auth.

Function
REQ-019 The FSM SHALL have states IDLE, SEND, WAIT, RESP; s_ready=1 only in IDLE.
REQ-020 On s_valid&&s_ready, the block SHALL latch s_data, s_type, s_flags, clamped s_nbeats, clear the response register, and enter SEND.
REQ-021 SEND (one cycle) SHALL drive bd_in_data=shift[127:112], invert tx_toggle, set last=1 only on the final beat, then enter WAIT.
REQ-022 bd_in_data and bd_in_config SHALL be registered and held stable from SEND until the next SEND or return to IDLE.
REQ-023 In WAIT, bd_out_config[2]==tx_toggle SHALL complete the beat: resp<={resp[111:0],bd_out_data}, shift<<=16, beats decrement.
REQ-024 After a completed beat, the FSM SHALL enter SEND if beats remain, else RESP, latching m_auth from the same-cycle bd_out_config[3].
REQ-025 A per-beat counter SHALL reset on SEND; reaching TIMEOUT_CYCLES in WAIT SHALL set m_timeout=1 and enter RESP with partial data.
REQ-026 In RESP, m_valid=1 with m_data/m_auth/m_timeout stable until m_ready; on m_valid&&m_ready return to IDLE.
REQ-027 Minimum per-beat latency SHALL be 2 cycles (SEND + one WAIT cycle); an 8-beat block with immediate echo completes in 16 cycles before RESP.
REQ-028 tx_toggle SHALL persist across requests (never re-zeroed except by reset) to stay coherent with the engine.
REQ-029 An echo edge arriving in IDLE, SEND or RESP SHALL be ignored.

Reset
REQ-030 While rst=0: state=IDLE, tx_toggle=0, bd_in_data=0, bd_in_config=0, s_ready=0, m_valid=0, m_data=0, m_auth=0, m_timeout=0, counters=0.
REQ-031 s_ready SHALL assert the first cycle after rst deasserts.
REQ-032 Reset mid-transfer SHALL discard all latched data; no partial response is emitted.

Structure
REQ-033 Type codes and config bit positions (toggle=0, flags=5:1, last=6, type=10:7, echo=2, auth=3) SHALL come from the shared ascon_constants.vh header.
REQ-034 The block SHALL be a single module without sub-modules; the timeout counter is inline.

Verification
REQ-035 Key 000102030405060708090A0B0C0D0E0F, type KEY, nbeats=8, echoing model -> bd_in_data 0x0001,0x0203,...,0x0E0F; last=1 only on beat 8; toggle 1,0,1,...,0.
REQ-036 CONF, flags=5'b10110, nbeats=1 -> one beat, bd_in_config flags field 10110, last=1; RESP after 2 cycles.
REQ-037 OK, nbeats=8, model returns 0x8000 then seven 0x0000, auth=1 -> m_data=0x80000000000000000000000000000000, m_auth=1.
REQ-038 Engine model stops echoing after beat 3, TIMEOUT_CYCLES=16 -> m_timeout=1, m_data[47:0] holds three words, upper bits 0.
REQ-039 m_ready held 0 for 10 cycles in RESP -> m_valid and m_data stable, s_ready=0; back-to-back request then starts with continued toggle.
REQ-040 rst asserted during WAIT of beat 5 -> all outputs at reset values immediately, s_ready=1 one cycle after release, no m_valid.

Source files
------------

// File: rtl/ascon_bd_sequencer_pkg.sv
// Shared codes and bit positions for the Ascon block-data sequencer.
// Imported by the sequencer and anything that talks to the engine port.
package ascon_bd_sequencer_pkg;

  localparam logic [3:0] T_CONF    = 4'h1;
  localparam logic [3:0] T_KEY     = 4'h2;
  localparam logic [3:0] T_NONCE   = 4'h3;
  localparam logic [3:0] T_TAG     = 4'h4;
  localparam logic [3:0] T_AD      = 4'h5;
  localparam logic [3:0] T_SKIP_AD = 4'h6;
  localparam logic [3:0] T_PLAIN   = 4'h7;
  localparam logic [3:0] T_CIPHER  = 4'h8;
  localparam logic [3:0] T_OK      = 4'h9;

  localparam int CFG_TOG      = 0;
  localparam int CFG_FLAGS_LO = 1;
  localparam int CFG_FLAGS_HI = 5;
  localparam int CFG_LAST     = 6;
  localparam int CFG_TYPE_LO  = 7;
  localparam int CFG_TYPE_HI  = 10;
  localparam int CFG_ECHO     = 2;
  localparam int CFG_AUTH     = 3;

  localparam logic [3:0] MAX_BEATS = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_RESP
  } state_t;

  function automatic logic [3:0] clamp_beats(
    input logic [3:0] n
  );
    logic [3:0] r;
    r = n;
    if (n == 4'd0)
      r = 4'd1;
    else if (n > MAX_BEATS)
      r = MAX_BEATS;
    return r;
  endfunction

  function automatic logic [15:0] pack_cfg(
    input logic [3:0] typ,
    input logic       last,
    input logic [4:0] flags,
    input logic       tog
  );
    logic [15:0] c;
    c = '0;
    c[CFG_TOG] = tog;
    c[CFG_FLAGS_HI:CFG_FLAGS_LO] = flags;
    c[CFG_LAST] = last;
    c[CFG_TYPE_HI:CFG_TYPE_LO] = typ;
    return c;
  endfunction

endpackage

// File: rtl/ascon_bd_sequencer.sv
// Splits a 128-bit request into 16-bit engine beats with toggle
// handshaking, collects the engine words and returns one response.
module ascon_bd_sequencer
  import ascon_bd_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [127:0] s_data,
  input  logic [3:0]   s_type,
  input  logic [4:0]   s_flags,
  input  logic [3:0]   s_nbeats,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [127:0] m_data,
  output logic         m_auth,
  output logic         m_timeout,
  output logic [15:0]  bd_in_data,
  output logic [15:0]  bd_in_config,
  input  logic [15:0]  bd_out_data,
  input  logic [15:0]  bd_out_config
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_t         r_state;
  logic [127:0]   r_shift;
  logic [127:0]   r_resp;
  logic [3:0]     r_type;
  logic [4:0]     r_flags;
  logic [3:0]     r_beats;
  logic           r_tog;
  logic [CW-1:0]  r_cnt;
  logic [15:0]    r_bd_data;
  logic [15:0]    r_bd_cfg;
  logic           r_s_ready;
  logic           r_m_valid;
  logic           r_auth;
  logic           r_tmo;

  logic           w_echo;
  logic           w_last;
  logic           w_tmo;
  logic           w_unused;

  assign w_echo = (bd_out_config[CFG_ECHO] == r_tog);
  assign w_last = (r_beats == 4'd1);
  assign w_tmo  = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  assign w_unused = ^{bd_out_config[15:4],
                      bd_out_config[1:0]};

  assign s_ready      = r_s_ready;
  assign m_valid      = r_m_valid;
  assign m_data       = r_resp;
  assign m_auth       = r_auth;
  assign m_timeout    = r_tmo;
  assign bd_in_data   = r_bd_data;
  assign bd_in_config = r_bd_cfg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_resp    <= '0;
      r_type    <= '0;
      r_flags   <= '0;
      r_beats   <= '0;
      r_tog     <= 1'b0;
      r_cnt     <= '0;
      r_bd_data <= '0;
      r_bd_cfg  <= '0;
      r_s_ready <= 1'b0;
      r_m_valid <= 1'b0;
      r_auth    <= 1'b0;
      r_tmo     <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_s_ready <= 1'b1;
          if (s_valid && r_s_ready) begin
            r_shift   <= s_data;
            r_type    <= s_type;
            r_flags   <= s_flags;
            r_beats   <= clamp_beats(s_nbeats);
            r_resp    <= '0;
            r_auth    <= 1'b0;
            r_tmo     <= 1'b0;
            r_s_ready <= 1'b0;
            r_state   <= ST_SEND;
          end
        end
        ST_SEND: begin
          r_bd_data <= r_shift[127:112];
          r_bd_cfg  <= pack_cfg(r_type, w_last,
                                r_flags, ~r_tog);
          r_tog     <= ~r_tog;
          r_cnt     <= '0;
          r_state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (w_echo) begin
            r_resp  <= {r_resp[111:0], bd_out_data};
            r_shift <= {r_shift[111:0], 16'h0000};
            r_beats <= r_beats - 4'd1;
            r_cnt   <= '0;
            if (w_last) begin
              r_auth    <= bd_out_config[CFG_AUTH];
              r_m_valid <= 1'b1;
              r_state   <= ST_RESP;
            end else begin
              r_state <= ST_SEND;
            end
          end else if (w_tmo) begin
            // give up on this beat; partial words stay in r_resp
            r_tmo     <= 1'b1;
            r_m_valid <= 1'b1;
            r_state   <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_RESP: begin
          if (m_ready) begin
            r_m_valid <= 1'b0;
            r_s_ready <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_bd_sequencer.sv
// Scoreboard bench: beat and response expectations are queued by the
// stimulus and popped by independent monitors.
module tb_ascon_bd_sequencer;
  import ascon_bd_sequencer_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [127:0] s_data = '0;
  logic [3:0]   s_type = '0;
  logic [4:0]   s_flags = '0;
  logic [3:0]   s_nbeats = '0;
  logic         m_valid;
  logic         m_ready = 1'b1;
  logic [127:0] m_data;
  logic         m_auth;
  logic         m_timeout;
  logic [15:0]  bd_in_data;
  logic [15:0]  bd_in_config;
  logic [15:0]  bd_out_data;
  logic [15:0]  bd_out_config;

  always #5 clk = ~clk;

  ascon_bd_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_type(s_type),
    .s_flags(s_flags), .s_nbeats(s_nbeats),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_auth(m_auth),
    .m_timeout(m_timeout),
    .bd_in_data(bd_in_data),
    .bd_in_config(bd_in_config),
    .bd_out_data(bd_out_data),
    .bd_out_config(bd_out_config)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(string nm, logic [127:0] act,
                     logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // engine model: echoes the toggle until stop_at beats were seen
  int          sends = 0;
  int          stop_at = 1000000;
  int          eng_base = 0;
  int          eng_i;
  logic [15:0] eng_tab [8];
  logic [15:0] eng_word = '0;
  logic        eng_auth = 1'b0;
  logic        last_tog = 1'b0;

  assign bd_out_data = eng_word;
  assign bd_out_config = {12'h000, eng_auth,
    (sends <= stop_at) ? bd_in_config[0] : ~bd_in_config[0],
    2'b00};

  typedef struct {
    logic [15:0] d;
    logic [15:0] c;
  } beat_t;
  typedef struct {
    logic [127:0] d;
    logic         a;
    logic         t;
    int           lat;
  } rsp_t;

  beat_t beat_q[$];
  rsp_t  rsp_q[$];
  logic  exp_tog = 1'b0;
  int    t_acc = 0;
  int    lat_meas = 0;
  logic  prev_v = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      last_tog = 1'b0;
    end else if (bd_in_config[0] !== last_tog) begin
      beat_t b;
      last_tog = bd_in_config[0];
      sends++;
      eng_i = sends - eng_base - 1;
      eng_word = (eng_i >= 0 && eng_i < 8) ?
                 eng_tab[eng_i] : 16'hDEAD;
      if (beat_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL beat_unexpected: got cfg %h expected none",
                 bd_in_config);
      end else begin
        b = beat_q.pop_front();
        chk("bd_in_data", 128'(bd_in_data), 128'(b.d));
        chk("bd_in_config", 128'(bd_in_config), 128'(b.c));
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid && !prev_v) lat_meas = cyc - t_acc;
    prev_v = m_valid;
    if (m_valid && m_ready) begin
      rsp_t r;
      if (rsp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got %h expected none", m_data);
      end else begin
        r = rsp_q.pop_front();
        chk("m_data", m_data, r.d);
        chk("m_auth", 128'(m_auth), 128'(r.a));
        chk("m_timeout", 128'(m_timeout), 128'(r.t));
        if (r.lat >= 0)
          chk("latency", 128'(lat_meas), 128'(r.lat));
      end
    end
  end

  task automatic push_beats(logic [3:0] typ, logic [4:0] fl,
                            int nb, int nsent, logic [127:0] d);
    for (int i = 0; i < nsent; i++) begin
      beat_t b;
      exp_tog = ~exp_tog;
      b.d = d[127-16*i -: 16];
      b.c = {5'b00000, typ, (i == nb - 1), fl, exp_tog};
      beat_q.push_back(b);
    end
  endtask

  task automatic push_rsp(logic [127:0] d, logic a,
                          logic t, int lat);
    rsp_t r;
    r.d = d;
    r.a = a;
    r.t = t;
    r.lat = lat;
    rsp_q.push_back(r);
  endtask

  task automatic issue(logic [3:0] typ, logic [4:0] fl,
                       logic [3:0] nb, logic [127:0] d);
    int n = 0;
    eng_base = sends;
    while (!s_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!s_ready) begin
      checks++;
      errors++;
      $display("FAIL s_ready_wait: got 0 expected 1");
      return;
    end
    s_valid = 1'b1;
    s_type = typ;
    s_flags = fl;
    s_nbeats = nb;
    s_data = d;
    @(posedge clk); #1;
    t_acc = cyc;
    s_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (rsp_q.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (rsp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL rsp_wait: got %0d pending expected 0",
               rsp_q.size());
      rsp_q.delete();
    end
  endtask

  logic [127:0] key;
  int n;

  initial begin
    key = 128'h000102030405060708090A0B0C0D0E0F;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", 128'(s_ready), 128'(0));
    chk("rst_m_valid", 128'(m_valid), 128'(0));
    chk("rst_m_data", m_data, 128'h0);
    chk("rst_bd_cfg", 128'(bd_in_config), 128'(0));
    chk("rst_bd_data", 128'(bd_in_data), 128'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    chk("rel_s_ready0", 128'(s_ready), 128'(0));
    @(posedge clk); #1;
    chk("rel_s_ready1", 128'(s_ready), 128'(1));

    // KEY, 8 beats, immediate echo
    eng_tab = '{16'h00F1, 16'h00F2, 16'h00F3, 16'h00F4,
                16'h00F5, 16'h00F6, 16'h00F7, 16'h00F8};
    push_beats(T_KEY, 5'b00000, 8, 8, key);
    push_rsp(128'h00F1_00F2_00F3_00F4_00F5_00F6_00F7_00F8,
             1'b0, 1'b0, 16);
    issue(T_KEY, 5'b00000, 4'd8, key);
    wait_rsp();

    // CONF, one beat with flags
    eng_tab[0] = 16'h5A5A;
    push_beats(T_CONF, 5'b10110, 1, 1, 128'hBEEF << 112);
    push_rsp(128'h5A5A, 1'b0, 1'b0, 2);
    issue(T_CONF, 5'b10110, 4'd1, 128'hBEEF << 112);
    wait_rsp();

    // OK with auth
    eng_tab = '{16'h8000, 16'h0000, 16'h0000, 16'h0000,
                16'h0000, 16'h0000, 16'h0000, 16'h0000};
    eng_auth = 1'b1;
    push_beats(T_OK, 5'b00011, 8, 8, ~key);
    push_rsp(128'h8000 << 112, 1'b1, 1'b0, 16);
    issue(T_OK, 5'b00011, 4'd8, ~key);
    wait_rsp();
    eng_auth = 1'b0;

    // nbeats clamping: 0 -> 1, 15 -> 8
    eng_tab[0] = 16'h1234;
    push_beats(T_NONCE, 5'b00100, 1, 1, key);
    push_rsp(128'h1234, 1'b0, 1'b0, 2);
    issue(T_NONCE, 5'b00100, 4'd0, key);
    wait_rsp();
    eng_tab = '{16'h0101, 16'h0202, 16'h0303, 16'h0404,
                16'h0505, 16'h0606, 16'h0707, 16'h0808};
    push_beats(T_AD, 5'b01000, 8, 8, key);
    push_rsp(128'h0101_0202_0303_0404_0505_0606_0707_0808,
             1'b0, 1'b0, 16);
    issue(T_AD, 5'b01000, 4'd15, key);
    wait_rsp();

    // engine goes silent after beat 3
    eng_tab = '{16'h1111, 16'h2222, 16'h3333, 16'h0000,
                16'h0000, 16'h0000, 16'h0000, 16'h0000};
    stop_at = sends + 3;
    push_beats(T_PLAIN, 5'b00000, 5, 4,
               128'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000_1111);
    push_rsp(128'h1111_2222_3333, 1'b0, 1'b1, -1);
    issue(T_PLAIN, 5'b00000, 4'd5,
          128'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000_1111);
    wait_rsp();
    stop_at = 1000000;

    // stalled response, then back-to-back request
    m_ready = 1'b0;
    eng_tab[0] = 16'hC001;
    eng_tab[1] = 16'hC002;
    push_beats(T_CIPHER, 5'b11111, 2, 2, key);
    push_rsp(128'hC001_C002, 1'b0, 1'b0, 4);
    issue(T_CIPHER, 5'b11111, 4'd2, key);
    n = 0;
    while (!m_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_m_valid", 128'(m_valid), 128'(1));
      chk("stall_m_data", m_data, 128'hC001_C002);
      chk("stall_s_ready", 128'(s_ready), 128'(0));
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    eng_tab[0] = 16'h7A7A;
    push_beats(T_TAG, 5'b00001, 1, 1, 128'h4321 << 112);
    push_rsp(128'h7A7A, 1'b0, 1'b0, 2);
    issue(T_TAG, 5'b00001, 4'd1, 128'h4321 << 112);
    wait_rsp();

    // reset while waiting on beat 5
    eng_tab = '{16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D,
                16'h0E0E, 16'h0F0F, 16'h0000, 16'h0000};
    stop_at = sends + 4;
    push_beats(T_KEY, 5'b00000, 8, 5, key);
    issue(T_KEY, 5'b00000, 4'd8, key);
    n = 0;
    while (sends < eng_base + 5 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rst_beats_sent", 128'(sends - eng_base), 128'(5));
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_s_ready", 128'(s_ready), 128'(0));
    chk("mid_m_valid", 128'(m_valid), 128'(0));
    chk("mid_m_data", m_data, 128'h0);
    chk("mid_flags", 128'({m_auth, m_timeout}), 128'(0));
    chk("mid_bd_data", 128'(bd_in_data), 128'(0));
    chk("mid_bd_cfg", 128'(bd_in_config), 128'(0));
    exp_tog = 1'b0;
    beat_q.delete();
    stop_at = 1000000;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rel_s_ready0", 128'(s_ready), 128'(0));
    @(posedge clk); #1;
    chk("mid_rel_s_ready1", 128'(s_ready), 128'(1));
    chk("mid_rel_m_valid", 128'(m_valid), 128'(0));

    // fresh start: toggle restarts at 1
    eng_tab[0] = 16'h0F0F;
    push_beats(T_SKIP_AD, 5'b00001, 1, 1, 128'h9999 << 112);
    push_rsp(128'h0F0F, 1'b0, 1'b0, 2);
    issue(T_SKIP_AD, 5'b00001, 4'd1, 128'h9999 << 112);
    wait_rsp();

    repeat (4) @(posedge clk);
    chk("beat_q_empty", 128'(beat_q.size()), 128'(0));
    chk("rsp_q_empty", 128'(rsp_q.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
